// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer in front of the single-port MIPS data memory.
// Optional macro DMEM_ARB_RR_EN: round-robin tie-break in IDLE (undefined: port 0 wins ties).
module dmem_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
    parameter int unsigned DEPTH     = 2048,
    parameter int unsigned HOLD_MAX  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        err0,
    output logic        err1,
    output logic        stall0,
    output logic        mem_ena,
    output logic        mem_wena,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [32:0] ADDR_LIMIT = {1'b0, BASE_ADDR} + (33'(DEPTH) * 33'd4);
    localparam logic [7:0]  HOLD_LIM   = 8'(HOLD_MAX);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [7:0]  hold_r;
    logic [7:0]  hold_nxt_s;
    logic        tie_pick1_s;
    logic        other_req_s;
    logic        own_s;
    logic        acc_we_s;
    logic        acc_inr_s;
    logic [31:0] acc_addr_s;
    logic [31:0] acc_wdata_s;
    logic        rvalid0_r;
    logic        rvalid1_r;
    logic        err0_r;
    logic        err1_r;
    logic [31:0] rdata0_r;
    logic [31:0] rdata1_r;

    // Unsigned 33-bit window check so BASE_ADDR + 4*DEPTH cannot wrap.
    function automatic logic in_range(input logic [31:0] a);
        in_range = ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < ADDR_LIMIT);
    endfunction

`ifdef DMEM_ARB_RR_EN
    logic last_r;

    // Remember the most recent owner; resets to 1 so port 0 takes the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_r <= 1'b1;
        end else if (state_r == OWN0) begin
            last_r <= 1'b0;
        end else if (state_r == OWN1) begin
            last_r <= 1'b1;
        end else begin
            last_r <= last_r;
        end
    end

    assign tie_pick1_s = ~last_r;
`else
    assign tie_pick1_s = 1'b0;
`endif

    // Select the owning port's access and flag whether the other port is waiting.
    always_comb begin
        own_s       = 1'b0;
        acc_we_s    = 1'b0;
        acc_addr_s  = 32'd0;
        acc_wdata_s = 32'd0;
        other_req_s = 1'b0;
        case (state_r)
            OWN0: begin
                own_s       = 1'b1;
                acc_we_s    = we0;
                acc_addr_s  = addr0;
                acc_wdata_s = wdata0;
                other_req_s = req1;
            end
            OWN1: begin
                own_s       = 1'b1;
                acc_we_s    = we1;
                acc_addr_s  = addr1;
                acc_wdata_s = wdata1;
                other_req_s = req0;
            end
            default: begin
                own_s       = 1'b0;
            end
        endcase
        acc_inr_s = in_range(acc_addr_s);
    end

    // Next ownership and hold counter; hold bounds an owner only while the other port waits.
    always_comb begin
        state_nxt_s = state_r;
        hold_nxt_s  = hold_r;
        case (state_r)
            IDLE: begin
                if (req0 && req1) begin
                    state_nxt_s = tie_pick1_s ? OWN1 : OWN0;
                end else if (req0) begin
                    state_nxt_s = OWN0;
                end else if (req1) begin
                    state_nxt_s = OWN1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            OWN0: begin
                if (req0) begin
                    state_nxt_s = (req1 && (hold_r >= HOLD_LIM)) ? OWN1 : OWN0;
                end else if (req1) begin
                    state_nxt_s = OWN1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            OWN1: begin
                if (req1) begin
                    state_nxt_s = (req0 && (hold_r >= HOLD_LIM)) ? OWN0 : OWN1;
                end else if (req0) begin
                    state_nxt_s = OWN0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        if (state_nxt_s != state_r) begin
            hold_nxt_s = 8'd0;
        end else if (own_s && other_req_s && (hold_r < HOLD_LIM)) begin
            hold_nxt_s = hold_r + 8'd1;
        end else begin
            hold_nxt_s = hold_r;
        end
    end

    // Ownership state and hold counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            hold_r  <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            hold_r  <= hold_nxt_s;
        end
    end

    // Per-port response capture at the end of each granted cycle; rdata holds between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid0_r <= 1'b0;
            rvalid1_r <= 1'b0;
            err0_r    <= 1'b0;
            err1_r    <= 1'b0;
            rdata0_r  <= 32'd0;
            rdata1_r  <= 32'd0;
        end else begin
            rvalid0_r <= (state_r == OWN0);
            rvalid1_r <= (state_r == OWN1);
            err0_r    <= (state_r == OWN0) && !acc_inr_s;
            err1_r    <= (state_r == OWN1) && !acc_inr_s;
            if (state_r == OWN0) begin
                rdata0_r <= (!acc_we_s && acc_inr_s) ? mem_rdata : 32'd0;
            end else begin
                rdata0_r <= rdata0_r;
            end
            if (state_r == OWN1) begin
                rdata1_r <= (!acc_we_s && acc_inr_s) ? mem_rdata : 32'd0;
            end else begin
                rdata1_r <= rdata1_r;
            end
        end
    end

    assign gnt0      = (state_r == OWN0);
    assign gnt1      = (state_r == OWN1);
    assign stall0    = req0 & ~gnt0;
    assign rvalid0   = rvalid0_r;
    assign rvalid1   = rvalid1_r;
    assign err0      = err0_r;
    assign err1      = err1_r;
    assign rdata0    = rdata0_r;
    assign rdata1    = rdata1_r;
    assign mem_ena   = own_s;
    assign mem_wena  = own_s & acc_we_s & acc_inr_s;
    assign mem_addr  = acc_addr_s;
    assign mem_wdata = acc_wdata_s;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural ownership/memory model.
module tb_dmem_arbiter;

    localparam logic [31:0] BASE     = 32'h1001_0000;
    localparam int          DEPTH    = 2048;
    localparam int          HOLD_MAX = 8;
`ifdef DMEM_ARB_RR_EN
    localparam int TIE2_PORT = 1;
`else
    localparam int TIE2_PORT = 0;
`endif

    logic        clk;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, stall0;
    logic [31:0] rdata0, rdata1;
    logic        mem_ena, mem_wena;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] dram    [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    int n_checks = 0;
    int n_errors = 0;

    // behavioural model: owner -1 = nobody
    int          m_owner;
    int          m_hold;
    int          m_last;
    logic        m_rv [2];
    logic        m_er [2];
    logic [31:0] m_rd [2];

    logic        pend_we;
    logic [31:0] pend_addr, pend_data;

    dmem_arbiter #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .HOLD_MAX(HOLD_MAX)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .stall0(stall0), .mem_ena(mem_ena), .mem_wena(mem_wena),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic in_rng(input logic [31:0] a);
        longint unsigned av, lo, hi;
        av = {32'd0, a};
        lo = {32'd0, BASE};
        hi = lo + 64'd4 * 64'(DEPTH);
        return (av >= lo) && (av < hi);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    assign mem_rdata = in_rng(mem_addr) ? dram[widx(mem_addr)] : 32'hBAD0_BAD0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_hold  = 0;
        m_last  = 1;
        for (int p = 0; p < 2; p++) begin
            m_rv[p] = 1'b0;
            m_er[p] = 1'b0;
            m_rd[p] = 32'd0;
        end
    endtask

    // Apply one clock edge to the model using the inputs held during the cycle.
    task automatic model_edge();
        logic        rq [2];
        logic        w;
        logic [31:0] a, d;
        int          o, q, nxt;
        if (rst) begin
            model_reset();
            return;
        end
        rq[0] = req0;
        rq[1] = req1;
        for (int p = 0; p < 2; p++) begin
            m_rv[p] = 1'b0;
            m_er[p] = 1'b0;
        end
        if (m_owner >= 0) begin
            o = m_owner;
            w = (o == 0) ? we0 : we1;
            a = (o == 0) ? addr0 : addr1;
            d = (o == 0) ? wdata0 : wdata1;
            m_rv[o] = 1'b1;
            m_er[o] = !in_rng(a);
            m_rd[o] = (!w && in_rng(a)) ? ref_mem[widx(a)] : 32'd0;
            if (w && in_rng(a)) ref_mem[widx(a)] = d;
        end
        if (m_owner < 0) begin
            if (rq[0] && rq[1]) begin
`ifdef DMEM_ARB_RR_EN
                nxt = (m_last == 1) ? 0 : 1;
`else
                nxt = 0;
`endif
            end else if (rq[0]) nxt = 0;
            else if (rq[1]) nxt = 1;
            else nxt = -1;
        end else begin
            o = m_owner;
            q = 1 - o;
            if (rq[o]) nxt = (rq[q] && m_hold == HOLD_MAX) ? q : o;
            else if (rq[q]) nxt = q;
            else nxt = -1;
            if (nxt == o && rq[q] && m_hold < HOLD_MAX) m_hold++;
        end
        if (nxt != m_owner) m_hold = 0;
        m_owner = nxt;
        if (m_owner >= 0) m_last = m_owner;
    endtask

    task automatic check_outputs();
        logic        own, w;
        logic [31:0] a, d;
        own = (m_owner >= 0);
        w   = (m_owner == 0) ? we0 : (m_owner == 1) ? we1 : 1'b0;
        a   = (m_owner == 0) ? addr0 : (m_owner == 1) ? addr1 : 32'd0;
        d   = (m_owner == 0) ? wdata0 : (m_owner == 1) ? wdata1 : 32'd0;
        check_eq("gnt", 32'({gnt1, gnt0}), 32'({m_owner == 1, m_owner == 0}));
        check_eq("stall0", 32'(stall0), 32'(req0 && m_owner != 0));
        check_eq("mem_ctl", 32'({mem_ena, mem_wena}), 32'({own, own && w && in_rng(a)}));
        check_eq("mem_addr", mem_addr, a);
        check_eq("mem_wdata", mem_wdata, d);
        check_eq("resp0", 32'({rvalid0, err0}), 32'({m_rv[0], m_er[0]}));
        check_eq("resp1", 32'({rvalid1, err1}), 32'({m_rv[1], m_er[1]}));
        check_eq("rdata0", rdata0, m_rd[0]);
        check_eq("rdata1", rdata1, m_rd[1]);
    endtask

    // One clock: check at negedge, commit the memory write and advance the model at posedge.
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        pend_we   = mem_wena;
        pend_addr = mem_addr;
        pend_data = mem_wdata;
        @(posedge clk);
        if (pend_we && in_rng(pend_addr)) dram[widx(pend_addr)] = pend_data;
        model_edge();
        #1;
    endtask

    task automatic check_image(input string tag);
        int nbad;
        nbad = 0;
        for (int i = 0; i < DEPTH; i++) if (dram[i] !== ref_mem[i]) nbad++;
        check_eq(tag, 32'(nbad), 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        int k;
        k = $urandom_range(0, 19);
        case (k)
            0: return BASE - 32'd4;
            1: return BASE + 32'(4 * DEPTH);
            2: return $urandom;
            3: return BASE;
            4: return BASE + 32'(4 * (DEPTH - 1));
            default: return BASE + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(0, 3));
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [31:0] v;
        for (int i = 0; i < DEPTH; i++) begin
            v = $urandom;
            dram[i] = v;
            ref_mem[i] = v;
        end
        rst = 1'b1; req0 = 1'b1; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = BASE; addr1 = 32'd0; wdata0 = 32'd0; wdata1 = 32'd0;
        model_reset();

        // reset with req0 high
        cycle();
        cycle();
        check_eq("rst_stall0", 32'(stall0), 32'd1);
        check_eq("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
        rst = 1'b0;
        cycle();
        check_eq("rst_release_gnt0", 32'(gnt0), 32'd1);

        // port 0 write then read of the same word
        we0 = 1'b1; addr0 = 32'h1001_0004; wdata0 = 32'hDEAD_BEEF;
        cycle();
        we0 = 1'b0; req0 = 1'b0;
        cycle();
        check_eq("p0_read_valid", 32'({rvalid0, err0}), 32'b10);
        check_eq("p0_read_data", rdata0, 32'hDEAD_BEEF);

        // port 1 out-of-range write just past the top of memory
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h1001_2000; wdata1 = 32'h1234_5678;
        cycle();
        req1 = 1'b0;
        #1;
        check_eq("oor_wena", 32'({gnt1, mem_wena}), 32'b10);
        cycle();
        check_eq("oor_err1", 32'({rvalid1, err1}), 32'b11);
        check_eq("oor_rdata1", rdata1, 32'd0);
        check_image("oor_mem_image");

        // starvation bound: port 1 holds, port 0 arrives
        req1 = 1'b1; we1 = 1'b0; addr1 = BASE + 32'd8;
        n = 0;
        do begin cycle(); n++; end while (!gnt1 && n < 20);
        check_eq("starve_gnt1", 32'(gnt1), 32'd1);
        req0 = 1'b1; we0 = 1'b0; addr0 = BASE + 32'd12;
        n = 0;
        while (gnt1 && n < 40) begin n++; cycle(); end
        check_eq("hold_cycles", 32'(n - 1), 32'(HOLD_MAX));
        check_eq("handover_gnt0", 32'({gnt1, gnt0}), 32'b01);
        req0 = 1'b0; req1 = 1'b0;
        cycle();
        cycle();

        // reset during a granted read
        req0 = 1'b1; we0 = 1'b0; addr0 = BASE + 32'd16;
        cycle();
        check_eq("midrst_gnt0", 32'(gnt0), 32'd1);
        rst = 1'b1; req0 = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("midrst_rvalid0", 32'(rvalid0), 32'd0);
        end
        rst = 1'b0;
        cycle();
        check_eq("midrst_idle", 32'({gnt1, gnt0, rvalid0}), 32'd0);

        // two ties from IDLE after reset
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        cycle();
        check_eq("tie1_port", 32'({gnt1, gnt0}), 32'b01);
        req0 = 1'b0; req1 = 1'b0;
        cycle();
        cycle();
        req0 = 1'b1; req1 = 1'b1;
        cycle();
        check_eq("tie2_port", 32'({gnt1, gnt0}), (TIE2_PORT == 1) ? 32'b10 : 32'b01);
        req0 = 1'b0; req1 = 1'b0;
        cycle();
        cycle();

        // randomized traffic with occasional reset
        for (int i = 0; i < 1500; i++) begin
            req0   = ($urandom_range(0, 9) < 6);
            req1   = ($urandom_range(0, 9) < 6);
            we0    = $urandom_range(0, 1);
            we1    = $urandom_range(0, 1);
            addr0  = rand_addr();
            addr1  = rand_addr();
            wdata0 = $urandom;
            wdata1 = $urandom;
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                model_reset();
                cycle();
                rst = 1'b0;
            end
            cycle();
        end
        req0 = 1'b0; req1 = 1'b0;
        cycle();
        cycle();
        check_image("final_mem_image");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
